tot_phase_generator: RTL and testbench

Synthesizable stimulus source for the ETROC2 TDC TOT path. It is the inverse of the TOT phase encoder: from a combined phase value it produces the 21-tap delay-line snapshot and the two ripple-counter values. It also produces the coarse and fine codes the encoder must return for that snapshot with offset 0. It drives the encoder in FPGA loop-back tests, either swept by an internal phase counter or loaded directly.

---
 rtl/tot_phase_generator_if.sv | 35 +++
 rtl/tot_phase_generator.sv | 138 +++++++++++++
 tb/tb_tot_phase_generator.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tot_phase_generator_if.sv
// Handshake and snapshot bundle between the TOT phase generator
// and its controller / encoder-under-test.
interface tot_phase_generator_if;
    logic        start;
    logic        stop;
    logic [3:0]  stepSize;
    logic        load;
    logic [2:0]  loadCoarse;
    logic [5:0]  loadFine;
    logic        errEn;
    logic [4:0]  errBit;
    logic        ack;
    logic [20:0] A;
    logic [2:0]  counterA;
    logic [2:0]  counterB;
    logic [2:0]  expCoarse;
    logic [5:0]  expFine;
    logic        valid;
    logic        busy;
    logic        loadErr;

    modport master (
        output start, stop, stepSize, load, loadCoarse, loadFine,
        output errEn, errBit, ack,
        input  A, counterA, counterB, expCoarse, expFine,
        input  valid, busy, loadErr
    );

    modport slave (
        input  start, stop, stepSize, load, loadCoarse, loadFine,
        input  errEn, errBit, ack,
        output A, counterA, counterB, expCoarse, expFine,
        output valid, busy, loadErr
    );
endinterface

// File: rtl/tot_phase_generator.sv
// Stimulus source for the ETROC2 TOT encoder: turns a combined phase
// into a delay-line snapshot, ripple-counter values and expected codes.
module tot_phase_generator (
    input logic                  clk,
    input logic                  rstn,
    tot_phase_generator_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [8:0]  p_q, p_d;
    logic [9:0]  sum;
    logic        upd, inj;
    logic        lerr_d, lerr_q;
    logic        valid_q, busy_q;
    logic [20:0] a_q, a_d;
    logic [2:0]  ca_q, ca_d, cb_q, cb_d;
    logic [5:0]  ef_q, ef_d;
    logic [20:0] flip;

    // 8 -> 0 falls out of the 3-bit cast, giving the mod-8 wrap
    function automatic logic [2:0] div42(input logic [9:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            if (v >= 10'(k * 42)) r = 3'(k);
        end
        return r;
    endfunction

    function automatic logic [5:0] mod42(
        input logic [8:0] p,
        input logic [2:0] c
    );
        logic [8:0] t;
        t = p - 9'(c) * 9'd42;
        return t[5:0];
    endfunction

    function automatic logic [20:0] snap(input logic [5:0] f);
        logic [20:0] a;
        for (int i = 0; i < 21; i++) begin
            if (f <= 6'd20) a[i] = (6'(i) <= f);
            else            a[i] = (6'(i) > (f - 6'd21));
        end
        return a;
    endfunction

    assign sum = {1'b0, p_q} + {6'd0, bus.stepSize};

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        upd     = 1'b0;
        inj     = 1'b0;
        lerr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    p_d     = 9'd0;
                    upd     = 1'b1;
                end else if (bus.load) begin
                    if (bus.loadFine <= 6'd41) begin
                        state_d = HOLD;
                        p_d     = 9'(bus.loadCoarse) * 9'd42
                                + 9'(bus.loadFine);
                        upd     = 1'b1;
                        inj     = bus.errEn;
                    end else begin
                        lerr_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                upd = 1'b1;
                if (bus.stop) begin
                    state_d = HOLD;
                    inj     = bus.errEn;
                end else if (sum >= 10'd336) begin
                    p_d = 9'(sum - 10'd336);
                end else begin
                    p_d = sum[8:0];
                end
            end
            HOLD: begin
                if (bus.ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        flip = 21'd0;
        if (inj && bus.errBit <= 5'd20) flip = 21'd1 << bus.errBit;
        cb_d = div42({1'b0, p_d});
        ef_d = mod42(p_d, cb_d);
        ca_d = div42({1'b0, p_d} + 10'd20);
        a_d  = snap(ef_d) ^ flip;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            p_q     <= 9'd0;
            a_q     <= 21'd0;
            ca_q    <= 3'd0;
            cb_q    <= 3'd0;
            ef_q    <= 6'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            valid_q <= (state_d == HOLD);
            busy_q  <= (state_d != IDLE);
            lerr_q  <= lerr_d;
            if (upd) begin
                a_q  <= a_d;
                ca_q <= ca_d;
                cb_q <= cb_d;
                ef_q <= ef_d;
            end
        end
    end

    assign bus.A         = a_q;
    assign bus.counterA  = ca_q;
    assign bus.counterB  = cb_q;
    assign bus.expCoarse = cb_q;
    assign bus.expFine   = ef_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = busy_q;
    assign bus.loadErr   = lerr_q;
endmodule

// File: tb/tb_tot_phase_generator.sv
// Directed bench for tot_phase_generator: load, injection, sweep,
// wrap, precedence and reset scenarios against hand-computed values.
module tb_tot_phase_generator;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   passed = 0;

    tot_phase_generator_if bus ();

    tot_phase_generator dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [38:0] obs();
        return {bus.A, bus.counterA, bus.counterB, bus.expCoarse,
                bus.expFine, bus.valid, bus.busy, bus.loadErr};
    endfunction

    function automatic logic [38:0] expv(
        input logic [20:0] a,
        input logic [2:0]  ca,
        input logic [2:0]  cb,
        input logic [2:0]  c,
        input logic [5:0]  f,
        input logic        v,
        input logic        b,
        input logic        e
    );
        return {a, ca, cb, c, f, v, b, e};
    endfunction

    task automatic idle_inputs();
        bus.start = 0; bus.stop = 0; bus.load = 0; bus.ack = 0;
        bus.errEn = 0; bus.errBit = 0;
        bus.loadCoarse = 0; bus.loadFine = 0; bus.stepSize = 1;
    endtask

    task automatic test_reset();
        logic [38:0] want;
        want = '0;
        for (int i = 0; i < 8; i++) begin
            bus.start = 1'($urandom); bus.stop = 1'($urandom);
            bus.load = 1'($urandom); bus.ack = 1'($urandom);
            bus.errEn = 1'($urandom); bus.errBit = 5'($urandom);
            bus.loadCoarse = 3'($urandom);
            bus.loadFine = 6'($urandom);
            bus.stepSize = 4'($urandom);
            step();
            total++;
            if (obs() !== want)
                $display("FAIL reset[%0d]: got %h want %h",
                         i, obs(), want);
            else passed++;
        end
        idle_inputs();
        rstn = 1; bus.ack = 1;
        step();
        bus.ack = 0;
        total++;
        if (obs() !== want)
            $display("FAIL reset_release: got %h want %h", obs(), want);
        else passed++;
    endtask

    task automatic test_load();
        logic [38:0] want;
        bus.loadCoarse = 3; bus.loadFine = 25; bus.load = 1;
        step();
        bus.load = 0;
        want = expv(21'h1FFFE0, 4, 3, 3, 25, 1, 1, 0);
        total++;
        if (obs() !== want)
            $display("FAIL load_3_25: got %h want %h", obs(), want);
        else passed++;
        bus.start = 1; bus.stop = 1; bus.load = 1; bus.loadFine = 0;
        step();
        bus.start = 0; bus.stop = 0; bus.load = 0;
        total++;
        if (obs() !== want)
            $display("FAIL hold_ignores: got %h want %h", obs(), want);
        else passed++;
        bus.ack = 1;
        step();
        bus.ack = 0;
        want = expv(21'h1FFFE0, 4, 3, 3, 25, 0, 0, 0);
        total++;
        if (obs() !== want)
            $display("FAIL load_ack: got %h want %h", obs(), want);
        else passed++;
    endtask

    task automatic test_error();
        logic [38:0] want;
        bus.loadCoarse = 0; bus.loadFine = 10;
        bus.errEn = 1; bus.errBit = 4; bus.load = 1;
        step();
        bus.load = 0; bus.errEn = 0;
        want = expv(21'h0007EF, 0, 0, 0, 10, 1, 1, 0);
        total++;
        if (obs() !== want)
            $display("FAIL inject_bit4: got %h want %h", obs(), want);
        else passed++;
        bus.ack = 1; step(); bus.ack = 0;
        bus.errEn = 1; bus.errBit = 25; bus.load = 1;
        step();
        bus.load = 0; bus.errEn = 0;
        want = expv(21'h0007FF, 0, 0, 0, 10, 1, 1, 0);
        total++;
        if (obs() !== want)
            $display("FAIL inject_none: got %h want %h", obs(), want);
        else passed++;
        bus.ack = 1; step(); bus.ack = 0;
        bus.loadCoarse = 2; bus.loadFine = 42; bus.load = 1;
        step();
        bus.load = 0;
        want = expv(21'h0007FF, 0, 0, 0, 10, 0, 0, 1);
        total++;
        if (obs() !== want)
            $display("FAIL load_reject: got %h want %h", obs(), want);
        else passed++;
        step();
        want = expv(21'h0007FF, 0, 0, 0, 10, 0, 0, 0);
        total++;
        if (obs() !== want)
            $display("FAIL reject_pulse: got %h want %h", obs(), want);
        else passed++;
    endtask

    task automatic test_stop41();
        logic [38:0] want;
        bus.stepSize = 1; bus.start = 1;
        step();
        bus.start = 0;
        want = expv(21'h000001, 0, 0, 0, 0, 0, 1, 0);
        total++;
        if (obs() !== want)
            $display("FAIL run_first: got %h want %h", obs(), want);
        else passed++;
        repeat (41) step();
        want = expv(21'h000000, 1, 0, 0, 41, 0, 1, 0);
        total++;
        if (obs() !== want)
            $display("FAIL run_p41: got %h want %h", obs(), want);
        else passed++;
        bus.stop = 1;
        step();
        bus.stop = 0;
        want = expv(21'h000000, 1, 0, 0, 41, 1, 1, 0);
        total++;
        if (obs() !== want)
            $display("FAIL stop_p41: got %h want %h", obs(), want);
        else passed++;
        step();
        total++;
        if (obs() !== want)
            $display("FAIL stop_frozen: got %h want %h", obs(), want);
        else passed++;
        bus.ack = 1; step(); bus.ack = 0;
    endtask

    task automatic test_sweep();
        int ones, zeros, df;
        logic [11:0] got, want;
        bus.stepSize = 1; bus.start = 1;
        step();
        bus.start = 0;
        for (int i = 0; i < 337; i++) begin
            ones = 0;
            for (int k = 0; k < 21; k++) ones += int'(bus.A[k]);
            zeros = 21 - ones;
            df = bus.A[0] ? ones - 1 : 20 + zeros;
            got  = {bus.counterA, bus.counterB,
                    bus.expCoarse == bus.counterB,
                    bus.expFine == 6'(df), bus.busy, bus.valid};
            want = {3'(((i % 336) + 20) / 42), 3'((i % 336) / 42),
                    1'b1, 1'b1, 1'b1, 1'b0};
            total++;
            if (got !== want || bus.expFine !== 6'((i % 336) % 42))
                $display("FAIL sweep[%0d]: got %h/%0d want %h/%0d",
                         i, got, bus.expFine, want, (i % 336) % 42);
            else passed++;
            step();
        end
        bus.stop = 1; step(); bus.stop = 0;
        bus.ack = 1; step(); bus.ack = 0;
    endtask

    task automatic test_wrap();
        logic [38:0] want;
        bus.stepSize = 7; bus.start = 1;
        step();
        bus.start = 0;
        repeat (47) step();
        want = expv(21'h1F8000, 0, 7, 7, 35, 0, 1, 0);
        total++;
        if (obs() !== want)
            $display("FAIL wrap_p329: got %h want %h", obs(), want);
        else passed++;
        step();
        want = expv(21'h000001, 0, 0, 0, 0, 0, 1, 0);
        total++;
        if (obs() !== want)
            $display("FAIL wrap_p0: got %h want %h", obs(), want);
        else passed++;
        bus.stop = 1; step(); bus.stop = 0;
        bus.ack = 1; step(); bus.ack = 0;
    endtask

    task automatic test_start_load();
        logic [38:0] want;
        bus.stepSize = 7; bus.loadCoarse = 5; bus.loadFine = 3;
        bus.start = 1; bus.load = 1;
        step();
        bus.start = 0; bus.load = 0;
        want = expv(21'h000001, 0, 0, 0, 0, 0, 1, 0);
        total++;
        if (obs() !== want)
            $display("FAIL start_over_load: got %h want %h",
                     obs(), want);
        else passed++;
        step();
        want = expv(21'h0000FF, 0, 0, 0, 7, 0, 1, 0);
        total++;
        if (obs() !== want)
            $display("FAIL start_load_p7: got %h want %h", obs(), want);
        else passed++;
        bus.stop = 1; step(); bus.stop = 0;
        bus.ack = 1; step(); bus.ack = 0;
    endtask

    task automatic test_reset_states();
        logic [38:0] want;
        bus.loadCoarse = 1; bus.loadFine = 0; bus.load = 1;
        step();
        bus.load = 0;
        want = expv(21'h000001, 1, 1, 1, 0, 1, 1, 0);
        total++;
        if (obs() !== want)
            $display("FAIL load_p42: got %h want %h", obs(), want);
        else passed++;
        want = '0;
        rstn = 0; bus.ack = 1; step(); rstn = 1; bus.ack = 0;
        total++;
        if (obs() !== want)
            $display("FAIL reset_hold: got %h want %h", obs(), want);
        else passed++;
        bus.ack = 1; step(); bus.ack = 0;
        total++;
        if (obs() !== want)
            $display("FAIL ack_after_rst: got %h want %h", obs(), want);
        else passed++;
        bus.stepSize = 3; bus.start = 1; step(); bus.start = 0;
        repeat (5) step();
        rstn = 0; step(); rstn = 1;
        total++;
        if (obs() !== want)
            $display("FAIL reset_run: got %h want %h", obs(), want);
        else passed++;
        bus.ack = 1; step(); bus.ack = 0;
        total++;
        if (obs() !== want)
            $display("FAIL ack_idle: got %h want %h", obs(), want);
        else passed++;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load();
        test_error();
        test_stop41();
        test_sweep();
        test_wrap();
        test_start_load();
        test_reset_states();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
